itch_feed_encoder: RTL and testbench

Generates the ITCH-style beat stream that `market_data_processor` consumes: accepts order-book events on a valid/ready input, queues them, and serialises each into a two-beat message (header plus trailer) on a 64-bit valid/ready output. Used as the exchange-side feed source in loopback and replay setups. It also emits periodic heartbeat beats when idle.

---
 rtl/itch_pkg.sv | 52 +++++
 rtl/sync_fifo.sv | 57 +++++
 rtl/itch_feed_encoder.sv | 171 +++++++++++++++++
 tb/tb_itch_feed_encoder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/itch_pkg.sv
// Shared ITCH feed definitions: beat type codes, action encoding, encoder FSM
// states and the queued event word layout.
package itch_pkg;

  localparam logic [7:0] TYPE_ADD    = 8'h41;  // 'A'
  localparam logic [7:0] TYPE_EXEC   = 8'h45;  // 'E'
  localparam logic [7:0] TYPE_CANCEL = 8'h58;  // 'X'
  localparam logic [7:0] TYPE_DELETE = 8'h44;  // 'D'
  localparam logic [7:0] TYPE_VOL    = 8'h56;  // 'V'
  localparam logic [7:0] TYPE_HB     = 8'h53;  // 'S'

  typedef enum logic [2:0] {
    ACT_ADD    = 3'd0,
    ACT_EXEC   = 3'd1,
    ACT_CANCEL = 3'd2,
    ACT_DELETE = 3'd3
  } action_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_TRL  = 2'd2,
    ST_HB   = 2'd3
  } state_e;

  // 3 + 32 + 32 + 32 + 1 = 100 bits
  typedef struct packed {
    logic [2:0]  action;
    logic [31:0] symbol;
    logic [31:0] price;
    logic [31:0] volume;
    logic        side;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);

  // Actions 4..7 are illegal and never reach the wire.
  function automatic logic action_legal(input logic [2:0] a);
    return !a[2];
  endfunction

  function automatic logic [7:0] hdr_type(input logic [2:0] a);
    case (a)
      ACT_ADD:    return TYPE_ADD;
      ACT_EXEC:   return TYPE_EXEC;
      ACT_CANCEL: return TYPE_CANCEL;
      ACT_DELETE: return TYPE_DELETE;
      default:    return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered empty flag and a registered ready
// (not-full) flag that is held low while in reset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             ready_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             empty_q, ready_q;
  logic             do_push, do_pop;

  assign do_push = push_i && ready_q;
  assign do_pop  = pop_i && !empty_q;
  assign data_o  = mem_q[rd_q];
  assign empty_o = empty_q;
  assign ready_o = ready_q;

  // Occupancy after this cycle's push/pop; flags are derived from it.
  always_comb begin
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Pointers, count and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      ready_q <= (cnt_d != (AW+1)'(DEPTH));
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/itch_feed_encoder.sv
// ITCH feed encoder: queues order-book events and serialises each into a
// header + trailer beat pair, with heartbeat beats while idle.
module itch_feed_encoder
  import itch_pkg::*;
#(
  parameter int FIFO_DEPTH       = 16,
  parameter int HEARTBEAT_CYCLES = 1024,
  parameter int SEQ_WIDTH        = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        evt_valid,
  output logic        evt_ready,
  input  logic [2:0]  evt_action,
  input  logic [31:0] evt_symbol,
  input  logic [31:0] evt_price,
  input  logic [31:0] evt_volume,
  input  logic        evt_side,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [63:0] tx_data,
  output logic [7:0]  tx_type,
  output logic [31:0] msgs_sent,
  output logic [31:0] beats_sent,
  output logic [15:0] illegal_events
);

  localparam bit          HB_EN   = (HEARTBEAT_CYCLES != 0);
  localparam logic [31:0] HB_LAST = HB_EN ? 32'(HEARTBEAT_CYCLES - 1) : 32'd0;

  evt_t fifo_din, fifo_dout;
  logic fifo_empty, fifo_pop;

  assign fifo_din = {evt_action, evt_symbol, evt_price, evt_volume, evt_side};

  sync_fifo #(.WIDTH(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (evt_valid && evt_ready),
    .data_i  (fifo_din),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .empty_o (fifo_empty),
    .ready_o (evt_ready)
  );

  state_e                 state_q, state_d;
  logic [63:0]            data_q, data_d;
  logic [7:0]             type_q, type_d;
  logic [31:0]            vol_q, vol_d;
  logic                   side_q, side_d;
  logic [SEQ_WIDTH-1:0]   seq_q, seq_d;
  logic [31:0]            msgs_q, msgs_d;
  logic [31:0]            beats_q, beats_d;
  logic [15:0]            ill_q, ill_d;
  logic [31:0]            hb_q, hb_d;
  logic                   hs, load_next, finish;
  logic [23:0]            seq24;

  assign tx_valid       = (state_q != ST_IDLE);
  assign hs             = tx_valid && tx_ready;
  assign seq24          = 24'(seq_q);
  assign tx_data        = data_q;
  assign tx_type        = type_q;
  assign msgs_sent      = msgs_q;
  assign beats_sent     = beats_q;
  assign illegal_events = ill_q;

  // Next state, beat formatting, FIFO pop and counter updates.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    type_d    = type_q;
    vol_d     = vol_q;
    side_d    = side_q;
    seq_d     = seq_q;
    msgs_d    = msgs_q;
    beats_d   = beats_q;
    ill_d     = ill_q;
    hb_d      = hb_q;
    fifo_pop  = 1'b0;
    load_next = 1'b0;
    finish    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load_next = 1'b1;
        end else if (HB_EN && hb_q == HB_LAST) begin
          state_d = ST_HB;
          type_d  = TYPE_HB;
          data_d  = {40'h0, seq24};
        end
      end
      ST_HDR: begin
        if (tx_ready) begin
          state_d = ST_TRL;
          type_d  = TYPE_VOL;
          data_d  = {vol_q, side_q, 7'h0, seq24};
        end
      end
      ST_TRL: begin
        if (tx_ready) begin
          finish    = 1'b1;
          state_d   = ST_IDLE;
          load_next = !fifo_empty;
        end
      end
      ST_HB: begin
        if (tx_ready) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pop and decode; illegal actions are dropped without a beat.
    if (load_next) begin
      fifo_pop = 1'b1;
      if (action_legal(fifo_dout.action)) begin
        state_d = ST_HDR;
        type_d  = hdr_type(fifo_dout.action);
        data_d  = {fifo_dout.symbol, fifo_dout.price};
        vol_d   = fifo_dout.volume;
        side_d  = fifo_dout.side;
      end else begin
        state_d = ST_IDLE;
        if (ill_q != 16'hFFFF) ill_d = ill_q + 16'd1;
      end
    end

    if (hs) beats_d = beats_q + 32'd1;
    if (finish) begin
      seq_d  = seq_q + SEQ_WIDTH'(1);
      msgs_d = msgs_q + 32'd1;
    end

    // Idle timer only runs while nothing is queued or moving.
    if (hs || !fifo_empty)       hb_d = 32'd0;
    else if (state_q == ST_IDLE) hb_d = hb_q + 32'd1;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      type_q  <= '0;
      vol_q   <= '0;
      side_q  <= 1'b0;
      seq_q   <= '0;
      msgs_q  <= '0;
      beats_q <= '0;
      ill_q   <= '0;
      hb_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      type_q  <= type_d;
      vol_q   <= vol_d;
      side_q  <= side_d;
      seq_q   <= seq_d;
      msgs_q  <= msgs_d;
      beats_q <= beats_d;
      ill_q   <= ill_d;
      hb_q    <= hb_d;
    end
  end

endmodule

// File: tb/tb_itch_feed_encoder.sv
// Self-checking bench for itch_feed_encoder: directed scenarios plus a
// randomized run, all beats checked against a queue-based message model.
module tb_itch_feed_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        evt_valid;
  logic        evt_ready;
  logic [2:0]  evt_action;
  logic [31:0] evt_symbol, evt_price, evt_volume;
  logic        evt_side;
  logic        tx_valid;
  logic        tx_ready;
  logic [63:0] tx_data;
  logic [7:0]  tx_type;
  logic [31:0] msgs_sent, beats_sent;
  logic [15:0] illegal_events;

  itch_feed_encoder #(.FIFO_DEPTH(16), .HEARTBEAT_CYCLES(8), .SEQ_WIDTH(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_action(evt_action),
    .evt_symbol(evt_symbol), .evt_price(evt_price), .evt_volume(evt_volume),
    .evt_side(evt_side),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_type(tx_type),
    .msgs_sent(msgs_sent), .beats_sent(beats_sent), .illegal_events(illegal_events)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  a;
    logic [31:0] sym, price, vol;
    logic        side;
  } ev_t;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] exp_code(input logic [2:0] a);
    case (a)
      3'd0: return 8'h41;
      3'd1: return 8'h45;
      3'd2: return 8'h58;
      default: return 8'h44;
    endcase
  endfunction

  // Reference model: accepted legal events in order, message-level counters.
  ev_t         evq[$];
  ev_t         cur;
  bit          mid = 0;
  logic [23:0] m_seq = 0;
  int          m_msgs = 0, m_beats = 0, m_ill = 0;
  int          hb_seen = 0, hb_last = 0, hb_gap = 0;
  bit          prev_stall = 0;
  logic [63:0] prev_data;
  logic [7:0]  prev_type;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: track accepted events and check every accepted beat.
  always @(negedge clk) begin
    if (!rst_n) begin
      evq.delete();
      mid = 0; m_seq = 0; m_msgs = 0; m_beats = 0; m_ill = 0; prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {63'h0, tx_valid}, 64'd1);
        chk("hold_data", tx_data, prev_data);
        chk("hold_type", {56'h0, tx_type}, {56'h0, prev_type});
      end
      if (evt_valid && evt_ready) begin
        ev_t e;
        e.a = evt_action; e.sym = evt_symbol; e.price = evt_price;
        e.vol = evt_volume; e.side = evt_side;
        if (e.a > 3'd3) m_ill++;
        else evq.push_back(e);
      end
      if (tx_valid && tx_ready) begin
        m_beats++;
        if (mid) begin
          chk("trl_type", {56'h0, tx_type}, 64'h56);
          chk("trl_data", tx_data, {cur.vol, cur.side, 7'h0, m_seq});
          m_seq++; m_msgs++; mid = 0;
        end else if (tx_type == 8'h53) begin
          chk("hb_data", tx_data, {40'h0, m_seq});
          m_seq++; m_msgs++;
          hb_gap = cyc - hb_last; hb_last = cyc; hb_seen++;
        end else if (evq.size() == 0) begin
          chk("unexpected_hdr", {56'h0, tx_type}, 64'h0);
        end else begin
          cur = evq.pop_front();
          chk("hdr_type", {56'h0, tx_type}, {56'h0, exp_code(cur.a)});
          chk("hdr_data", tx_data, {cur.sym, cur.price});
          mid = 1;
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_type  = tx_type;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offer one event and return just after the edge that accepts it.
  task automatic send(input ev_t e);
    int t = 0;
    evt_action = e.a; evt_symbol = e.sym; evt_price = e.price;
    evt_volume = e.vol; evt_side = e.side; evt_valid = 1'b1;
    while (!evt_ready && t < 200) begin tick(); t++; end
    if (t >= 200) chk("send_timeout", {63'h0, evt_ready}, 64'd1);
    tick();
    evt_valid = 1'b0;
  endtask

  function automatic ev_t mk(input logic [2:0] a, input logic [31:0] s, p, v, input logic sd);
    ev_t e;
    e.a = a; e.sym = s; e.price = p; e.vol = v; e.side = sd;
    return e;
  endfunction

  function automatic ev_t rnd_ev();
    ev_t e;
    e.a     = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
    e.sym   = $urandom; e.price = $urandom; e.vol = $urandom;
    e.side  = 1'($urandom);
    return e;
  endfunction

  // Wait until the model has nothing outstanding and the output is quiet.
  task automatic wait_quiet(input string tag);
    int t = 0;
    while (!(evq.size() == 0 && !mid && !tx_valid) && t < 1000) begin tick(); t++; end
    if (t >= 1000) chk(tag, {63'h0, tx_valid}, 64'd0);
  endtask

  bit rnd_done;

  initial begin
    int b0, m0, c0, h0, t;
    rst_n = 1'b0; evt_valid = 1'b0; evt_action = '0; evt_symbol = '0;
    evt_price = '0; evt_volume = '0; evt_side = 1'b0; tx_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_valid", {63'h0, tx_valid}, 64'd0);
    chk("rst_data", tx_data, 64'd0);
    chk("rst_type", {56'h0, tx_type}, 64'd0);
    chk("rst_ready", {63'h0, evt_ready}, 64'd0);
    chk("rst_msgs", {32'h0, msgs_sent}, 64'd0);
    chk("rst_beats", {32'h0, beats_sent}, 64'd0);
    chk("rst_ill", {48'h0, illegal_events}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", {63'h0, evt_ready}, 64'd1);

    // Single ADD: latency and beat contents
    tx_ready = 1'b1;
    send(mk(3'd0, 32'h41415054, 32'h32000000, 32'd100, 1'b0));
    chk("lat_k_idle", {63'h0, tx_valid}, 64'd0);
    tick();
    chk("lat_hdr_valid", {63'h0, tx_valid}, 64'd1);
    chk("add_type", {56'h0, tx_type}, 64'h41);
    chk("add_data", tx_data, 64'h41415054_32000000);
    tick();
    chk("add_trl_type", {56'h0, tx_type}, 64'h56);
    chk("add_trl_data", tx_data, {32'd100, 1'b0, 7'h0, 24'd0});
    tick();
    chk("add_msgs", {32'h0, msgs_sent}, 64'd1);
    chk("add_beats", {32'h0, beats_sent}, 64'd2);
    chk("add_idle", {63'h0, tx_valid}, 64'd0);

    // Header stall for 5 cycles
    tx_ready = 1'b0;
    send(mk(3'd3, 32'h4D534654, 32'h00001234, 32'd7, 1'b1));
    tick();
    b0 = beats_sent;
    repeat (5) tick();
    chk("stall_beats", {32'h0, beats_sent}, 64'(b0));
    chk("stall_type", {56'h0, tx_type}, 64'h44);
    chk("stall_msgs", {32'h0, msgs_sent}, 64'd1);
    tx_ready = 1'b1;
    tick();
    chk("stall_hdr_hs", {32'h0, beats_sent}, 64'(b0 + 1));
    chk("stall_trl_type", {56'h0, tx_type}, 64'h56);
    tick();
    chk("stall_msgs_done", {32'h0, msgs_sent}, 64'd2);

    // Burst of 20 EXEC: fill the queue with the sink stalled, then stream
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(mk(3'd1, 32'h45580000 + i, 32'h100 + i, 32'(i), 1'(i)));
    chk("burst_ready_15q", {63'h0, evt_ready}, 64'd1);
    send(mk(3'd1, 32'h45580010, 32'h110, 32'd16, 1'b0));
    chk("burst_full", {63'h0, evt_ready}, 64'd0);
    b0 = beats_sent; m0 = msgs_sent; c0 = cyc;
    tx_ready = 1'b1;
    for (int i = 17; i < 20; i++) send(mk(3'd1, 32'h45580000 + i, 32'h100 + i, 32'(i), 1'(i)));
    t = 0;
    while (cyc < c0 + 40 && t < 100) begin tick(); t++; end
    chk("burst_beats", {32'h0, beats_sent}, 64'(b0 + 40));
    chk("burst_msgs", {32'h0, msgs_sent}, 64'(m0 + 20));
    chk("burst_drained", {63'h0, tx_valid}, 64'd0);

    // Illegal action between two ADDs
    send(mk(3'd0, 32'h494E5443, 32'd55, 32'd10, 1'b0));
    send(mk(3'd5, 32'hDEADBEEF, 32'd1, 32'd1, 1'b1));
    send(mk(3'd0, 32'h494E5443, 32'd56, 32'd11, 1'b1));
    wait_quiet("ill_quiet");
    chk("ill_count", {48'h0, illegal_events}, 64'd1);
    chk("ill_msgs", {32'h0, msgs_sent}, 64'(m0 + 22));

    // Heartbeats while idle
    h0 = hb_seen; t = 0;
    while (hb_seen < h0 + 3 && t < 100) begin tick(); t++; end
    chk("hb_count", 64'(hb_seen - h0), 64'd3);
    chk("hb_period", 64'(hb_gap), 64'd9);

    // Randomized traffic with random backpressure
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 9) == 0) repeat ($urandom_range(8, 14)) tick();
          else repeat ($urandom_range(0, 2)) tick();
          send(rnd_ev());
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin tick(); tx_ready = ($urandom_range(0, 3) != 0); end
      end
    join
    tx_ready = 1'b1;
    wait_quiet("rnd_quiet");
    chk("rnd_msgs", {32'h0, msgs_sent}, 64'(m_msgs));
    chk("rnd_beats", {32'h0, beats_sent}, 64'(m_beats));
    chk("rnd_ill", {48'h0, illegal_events}, 64'(m_ill));

    // Reset while a trailer is stalled with events still queued
    tx_ready = 1'b0;
    send(mk(3'd2, 32'h52535431, 32'd9, 32'd9, 1'b0));
    tick();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    send(mk(3'd0, 32'h1, 32'h2, 32'h3, 1'b0));
    send(mk(3'd1, 32'h4, 32'h5, 32'h6, 1'b1));
    chk("pre_rst_trl", {56'h0, tx_type}, 64'h56);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", {63'h0, tx_valid}, 64'd0);
    chk("mid_rst_data", tx_data, 64'd0);
    chk("mid_rst_type", {56'h0, tx_type}, 64'd0);
    chk("mid_rst_ready", {63'h0, evt_ready}, 64'd0);
    chk("mid_rst_msgs", {32'h0, msgs_sent}, 64'd0);
    chk("mid_rst_beats", {32'h0, beats_sent}, 64'd0);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    repeat (5) tick();
    chk("post_rst_empty_beats", {32'h0, beats_sent}, 64'd0);
    chk("post_rst_empty_valid", {63'h0, tx_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
